vip_gray_rank_filter_3x3: RTL and testbench
===========================================

// Module: vip_gray_rank_filter_3x3
// PURPOSE
//   Parametrised 3x3 rank filter for the VIP gray pipeline: median, min (erode), max (dilate) or bypass.
//   Carries its own two line buffers and 3x3 window, so it sits directly after the Y conversion stage.
//   Sync signals pass through a matched delay; border pixels (incomplete window) get explicit handling.
// PARAMETERS
//   DATA_W   8    pixel width in bits
//   IMG_W    640  active pixels per line; sets line-buffer depth
//   ADDR_W   10   column counter/line-buffer address width; must satisfy 2**ADDR_W >= IMG_W
// PORTS
//   clk              in   1       pixel clock, all logic on rising edge
//   rst_n            in   1       asynchronous active-low reset
//   mode             in   2       0=median 1=min 2=max 3=bypass (center pixel)
//   per_frame_vsync  in   1       input frame valid
//   per_frame_href   in   1       input line valid
//   per_frame_clken  in   1       input pixel strobe
//   per_img_Y        in   DATA_W  input gray pixel
//   post_frame_vsync out  1       per_frame_vsync delayed LAT clocks
//   post_frame_href  out  1       per_frame_href delayed LAT clocks
//   post_frame_clken out  1       per_frame_clken delayed LAT clocks
//   post_img_Y       out  DATA_W  filtered pixel; 0 while post_frame_href low
// BEHAVIOUR
//   - Clock clk; reset rst_n is asynchronous, active-low. All outputs, counters, window regs, delay lines reset to 0.
//   - Line buffers are not cleared by reset; their contents are don't-care until refilled.
//   - Pixel accepted when per_frame_href & per_frame_clken. col_cnt increments per accepted pixel.
//   - col_cnt clears on href falling edge; row_cnt increments there (saturates at all-ones).
//   - row_cnt clears on per_frame_vsync rising edge.
//   - Window: newest column = {linebuf1 out, linebuf0 out, per_img_Y}; shifts on each accepted pixel.
//   - Line buffers write the same pixel column-aligned.
//   - Output pixel is the window centred one row and one column behind the newest input (spatial offset (-1,-1)).
//   - Fixed LAT = 6 clocks, independent of mode and of clken gaps:
//     2 window (buffer read + shift), 3 sort, 1 mode mux/output register.
//     Sync delay line is clocked every cycle; data pipeline is clocked every cycle as well, so gaps preserve alignment.
//   - Sort network:
//     s1: per row {max,mid,min}.
//     s2: max_of_mins, mid_of_mids, min_of_maxes, plus global min and global max.
//     s3: median = mid(max_of_mins, mid_of_mids, min_of_maxes).
//   - Comparisons are unsigned DATA_W-bit. Ties are legal and must give the exact rank value.
//   - mode is sampled only on per_frame_vsync rising edge into mode_q; it applies to the whole frame.
//     Mode changes mid-frame take effect at the next frame.
//   - Border: newest row_cnt<2 or newest col_cnt<2 marks the window incomplete.
//     The flag travels with the data pipeline; handling is set by RANK_BORDER_CLAMP_EN.
//   - href low during a line, or a line shorter than IMG_W: no error; counters follow the rules above.
//   - Lines longer than IMG_W: col_cnt wraps at IMG_W; result is undefined but must not hang.
//   - Reset mid-frame: outputs drop to 0 asynchronously.
//     After release, the first two rows of the next accepted data are border; no recovery handshake.
//   - Bypass (mode_q=3): post_img_Y = center pixel, same LAT, border handling identical.
// CONFIGURATION
//   RANK_BORDER_CLAMP_EN defined: border pixels output the raw center pixel (passthrough).
//   RANK_BORDER_CLAMP_EN undefined: border pixels output 0.
//   Non-border pixels are identical in both builds.
// TESTING
//   1 Reset: rst_n=0 mid-line with href=1 -> all post_* = 0 within same cycle; after release, rows 0-1 border.
//   2 Flat frame 8x4 (IMG_W=8), all pixels 0x55, mode=0 -> every non-border output 0x55,
//     post_frame_href = per_frame_href delayed exactly 6 clocks.
//   3 Impulse: 0x00 field with single 0xFF at (row2,col3), mode=0 -> no 0xFF at output;
//     mode=2 -> 3x3 block of 0xFF around the offset location; mode=1 -> all 0x00.
//   4 Window rows {9,1,5},{3,7,2},{8,4,6} at one center:
//     mode=0 -> 5; mode=1 -> 1; mode=2 -> 9; mode=3 -> 7.
//   5 Border build check: ramp frame -> with RANK_BORDER_CLAMP_EN the border equals the center pixel;
//     without it the border equals 0.
//   6 mode 0->2 toggled mid-frame -> current frame stays median; next frame after vsync rise is max.
//     Random clken gaps give outputs bit-identical to the gap-free run.

Source files
------------

// File: rtl/vip_gray_rank_filter_3x3.sv
// ---------------------------------------------------------------------------
// vip_gray_rank_filter_3x3
//   3x3 rank filter for the gray video pipeline: median, min (erode),
//   max (dilate) or bypass (center pixel). Holds two line buffers and the
//   3x3 window internally. The output pixel is the window centred one row
//   and one column behind the newest input. Fixed latency of 6 clocks:
//   stage 1 line-buffer read, stage 2 window shift, stages 3-5 sort,
//   stage 6 mode mux / output register. Sync signals use a matched delay.
//
// Configuration macro: RANK_BORDER_CLAMP_EN
//   defined   : border pixels (incomplete window) output the raw center pixel
//   undefined : border pixels output 0
//
// Ports
//   clk              pixel clock, rising edge
//   rst_n            asynchronous active-low reset
//   mode             0=median 1=min 2=max 3=bypass, sampled on vsync rise
//   per_frame_vsync  input frame valid
//   per_frame_href   input line valid
//   per_frame_clken  input pixel strobe
//   per_img_Y        input gray pixel
//   post_frame_*     sync inputs delayed 6 clocks
//   post_img_Y       filtered pixel, 0 while post_frame_href is low
// ---------------------------------------------------------------------------
module vip_gray_rank_filter_3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_Y,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y
);

  localparam int LAT = 6;

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  // Middle of three; exact under ties.
  function automatic logic [DATA_W-1:0] mid3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic              acc_s, vsync_rise_s, href_fall_s;
  logic              vsync_q, href_q;
  logic [ADDR_W-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [1:0]        mode_q, mode_d;

  logic [DATA_W-1:0] lb0_q [0:IMG_W-1];
  logic [DATA_W-1:0] lb1_q [0:IMG_W-1];

  logic              acc1_q, brd1_q;
  logic [ADDR_W-1:0] col1_q;
  logic [DATA_W-1:0] y1_q, lb0_rd_q, lb1_rd_q;
  logic [1:0]        mode1_q;

  logic [DATA_W-1:0] win_q [0:2][0:2];
  logic              brdw_q;
  logic [1:0]        modew_q;

  logic [DATA_W-1:0] rmax_q [0:2];
  logic [DATA_W-1:0] rmid_q [0:2];
  logic [DATA_W-1:0] rmin_q [0:2];
  logic [DATA_W-1:0] ctr_s1_q, ctr_s2_q, ctr_s3_q;
  logic              brd_s1_q, brd_s2_q, brd_s3_q;
  logic [1:0]        mode_s1_q, mode_s2_q, mode_s3_q;
  logic [DATA_W-1:0] mxmin_q, mdmid_q, mnmax_q, gmin_s2_q, gmax_s2_q;
  logic [DATA_W-1:0] med_q, gmin_s3_q, gmax_s3_q;

  logic [LAT-1:0]    vs_dly_q, hr_dly_q, ck_dly_q;
  logic [DATA_W-1:0] sel_s, pick_s, y_d, y_q;

  assign acc_s        = per_frame_href & per_frame_clken;
  assign vsync_rise_s = per_frame_vsync & ~vsync_q;
  assign href_fall_s  = href_q & ~per_frame_href;

  // Next-state for column/row counters and the per-frame mode register.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    mode_d    = mode_q;
    if (href_fall_s) begin
      col_cnt_d = '0;
    end else if (acc_s) begin
      col_cnt_d = (col_cnt_q == ADDR_W'(IMG_W - 1)) ? '0 : col_cnt_q + ADDR_W'(1);
    end else begin
      col_cnt_d = col_cnt_q;
    end
    if (vsync_rise_s) begin
      row_cnt_d = '0;
      mode_d    = mode;
    end else if (href_fall_s && (row_cnt_q != '1)) begin
      row_cnt_d = row_cnt_q + ADDR_W'(1);
    end else begin
      row_cnt_d = row_cnt_q;
    end
  end

  // Edge detectors, counters and frame mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      mode_q    <= 2'd0;
    end else begin
      vsync_q   <= per_frame_vsync;
      href_q    <= per_frame_href;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      mode_q    <= mode_d;
    end
  end

  // Stage 1: register the input pixel and read both line buffers at its column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1_q   <= 1'b0;
      col1_q   <= '0;
      y1_q     <= '0;
      lb0_rd_q <= '0;
      lb1_rd_q <= '0;
      brd1_q   <= 1'b0;
      mode1_q  <= 2'd0;
    end else begin
      acc1_q   <= acc_s;
      col1_q   <= col_cnt_q;
      y1_q     <= per_img_Y;
      lb0_rd_q <= lb0_q[col_cnt_q];
      lb1_rd_q <= lb1_q[col_cnt_q];
      brd1_q   <= (row_cnt_q < ADDR_W'(2)) || (col_cnt_q < ADDR_W'(2));
      mode1_q  <= mode_d;
    end
  end

  // Line buffers cascade column-aligned one cycle after the read; never cleared.
  always_ff @(posedge clk) begin
    if (acc1_q) begin
      lb0_q[col1_q] <= y1_q;
      lb1_q[col1_q] <= lb0_rd_q;
    end
  end

  // Stage 2: window shift on accepted pixel; row 0 is the oldest line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      brdw_q  <= 1'b0;
      modew_q <= 2'd0;
    end else begin
      if (acc1_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd_q;
        win_q[1][2] <= lb0_rd_q;
        win_q[2][2] <= y1_q;
        brdw_q      <= brd1_q;
      end
      modew_q <= mode1_q;
    end
  end

  // Stages 3-5: row sort, cross-row ranks, median; center/border/mode ride along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        rmax_q[r] <= '0;
        rmid_q[r] <= '0;
        rmin_q[r] <= '0;
      end
      {ctr_s1_q, ctr_s2_q, ctr_s3_q}    <= '0;
      {brd_s1_q, brd_s2_q, brd_s3_q}    <= '0;
      {mode_s1_q, mode_s2_q, mode_s3_q} <= '0;
      {mxmin_q, mdmid_q, mnmax_q}       <= '0;
      {gmin_s2_q, gmax_s2_q}            <= '0;
      {med_q, gmin_s3_q, gmax_s3_q}     <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        rmax_q[r] <= max3(win_q[r][0], win_q[r][1], win_q[r][2]);
        rmid_q[r] <= mid3(win_q[r][0], win_q[r][1], win_q[r][2]);
        rmin_q[r] <= min3(win_q[r][0], win_q[r][1], win_q[r][2]);
      end
      ctr_s1_q  <= win_q[1][1];
      brd_s1_q  <= brdw_q;
      mode_s1_q <= modew_q;

      mxmin_q   <= max3(rmin_q[0], rmin_q[1], rmin_q[2]);
      mdmid_q   <= mid3(rmid_q[0], rmid_q[1], rmid_q[2]);
      mnmax_q   <= min3(rmax_q[0], rmax_q[1], rmax_q[2]);
      gmin_s2_q <= min3(rmin_q[0], rmin_q[1], rmin_q[2]);
      gmax_s2_q <= max3(rmax_q[0], rmax_q[1], rmax_q[2]);
      ctr_s2_q  <= ctr_s1_q;
      brd_s2_q  <= brd_s1_q;
      mode_s2_q <= mode_s1_q;

      med_q     <= mid3(mxmin_q, mdmid_q, mnmax_q);
      gmin_s3_q <= gmin_s2_q;
      gmax_s3_q <= gmax_s2_q;
      ctr_s3_q  <= ctr_s2_q;
      brd_s3_q  <= brd_s2_q;
      mode_s3_q <= mode_s2_q;
    end
  end

  // Mode select, border handling and blanking outside active lines.
  always_comb begin
    sel_s  = ctr_s3_q;
    pick_s = '0;
    y_d    = '0;
    case (mode_s3_q)
      2'd0:    sel_s = med_q;
      2'd1:    sel_s = gmin_s3_q;
      2'd2:    sel_s = gmax_s3_q;
      2'd3:    sel_s = ctr_s3_q;
      default: sel_s = ctr_s3_q;
    endcase
    if (brd_s3_q) begin
`ifdef RANK_BORDER_CLAMP_EN
      pick_s = ctr_s3_q;
`else
      pick_s = '0;
`endif
    end else begin
      pick_s = sel_s;
    end
    // hr_dly_q[LAT-2] is the href that reaches the output with this pixel.
    if (hr_dly_q[LAT-2]) begin
      y_d = pick_s;
    end else begin
      y_d = '0;
    end
  end

  // Output register and matched sync delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly_q <= '0;
      hr_dly_q <= '0;
      ck_dly_q <= '0;
      y_q      <= '0;
    end else begin
      vs_dly_q <= {vs_dly_q[LAT-2:0], per_frame_vsync};
      hr_dly_q <= {hr_dly_q[LAT-2:0], per_frame_href};
      ck_dly_q <= {ck_dly_q[LAT-2:0], per_frame_clken};
      y_q      <= y_d;
    end
  end

  assign post_frame_vsync = vs_dly_q[LAT-1];
  assign post_frame_href  = hr_dly_q[LAT-1];
  assign post_frame_clken = ck_dly_q[LAT-1];
  assign post_img_Y       = y_q;

endmodule

// File: tb/tb_vip_gray_rank_filter_3x3.sv
// Testbench for vip_gray_rank_filter_3x3 (IMG_W=8). Stimulus pushes the
// expected pixel into a queue; a monitor pops and compares on every output
// pixel strobe and checks the sync delay line every cycle.
module tb_vip_gray_rank_filter_3x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       vs, hr, ck;
  logic [7:0] yin;
  logic       post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0] post_img_Y;

  always #5 clk = ~clk;

  vip_gray_rank_filter_3x3 #(.DATA_W(8), .IMG_W(8), .ADDR_W(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mode             (mode),
    .per_frame_vsync  (vs),
    .per_frame_href   (hr),
    .per_frame_clken  (ck),
    .per_img_Y        (yin),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Y       (post_img_Y)
  );

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    int         r;
    int         c;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] img [0:7][0:7];
  logic [7:0] hand_tab [0:3];
  logic [5:0] ref_vs, ref_hr, ref_ck;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference 6-clock delay of the sync inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_vs <= '0;
      ref_hr <= '0;
      ref_ck <= '0;
    end else begin
      ref_vs <= {ref_vs[4:0], vs};
      ref_hr <= {ref_hr[4:0], hr};
      ref_ck <= {ref_ck[4:0], ck};
    end
  end

  // Monitor: sync alignment every cycle, pixel compare on every output strobe.
  always @(negedge clk) begin
    chk8("post_vsync", {7'd0, post_frame_vsync}, {7'd0, ref_vs[5]});
    chk8("post_href",  {7'd0, post_frame_href},  {7'd0, ref_hr[5]});
    chk8("post_clken", {7'd0, post_frame_clken}, {7'd0, ref_ck[5]});
    if (!post_frame_href) begin
      chk8("blank_Y", post_img_Y, 8'h00);
    end
    if (post_frame_href && post_frame_clken) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0h, required no output", post_img_Y);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          chk8($sformatf("pix_r%0d_c%0d", mon_e.r, mon_e.c), post_img_Y, mon_e.exp);
        end
      end
    end
  end

  // Independent reference: full sort of the 9 window values.
  function automatic logic [7:0] model(input int r, input int c, input logic [1:0] m);
    logic [7:0] v [0:8];
    logic [7:0] t;
    int         k;
    k = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        v[k] = img[r-2+dr][c-2+dc];
        k = k + 1;
      end
    end
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0; j--) begin
        if (v[j-1] > v[j]) begin
          t = v[j]; v[j] = v[j-1]; v[j-1] = t;
        end
      end
    end
    case (m)
      2'd0:    return v[4];
      2'd1:    return v[0];
      2'd2:    return v[8];
      default: return img[r-1][c-1];
    endcase
  endfunction

  task automatic push_exp(input int r, input int c, input logic [1:0] m, input bit hand4);
    exp_t e;
    e.r = r;
    e.c = c;
    e.chk = 1'b1;
    e.exp = 8'h00;
    if (r < 2 || c < 2) begin
`ifdef RANK_BORDER_CLAMP_EN
      if (r >= 1 && c >= 1) e.exp = img[r-1][c-1];
      else e.chk = 1'b0;
`else
      e.exp = 8'h00;
`endif
    end else if (hand4 && r == 2 && c == 2) begin
      e.exp = hand_tab[m];
    end else begin
      e.exp = model(r, c, m);
    end
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input int rows, input logic [1:0] fmode, input logic [1:0] mid_mode,
                            input int mid_row, input bit gaps, input bit vs_high,
                            input int abort_cols, input bit hand4);
    mode = fmode;
    if (!vs_high) begin
      @(negedge clk);
      vs = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int r = 0; r < rows; r++) begin
      if (r == mid_row) mode = mid_mode;
      for (int c = 0; c < 8; c++) begin
        if (abort_cols > 0 && r == rows - 1 && c >= abort_cols) break;
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            hr = 1'b1; ck = 1'b0;
            @(negedge clk);
          end
        end
        hr = 1'b1; ck = 1'b1; yin = img[r][c];
        push_exp(r, c, fmode, hand4);
        @(negedge clk);
      end
      ck = 1'b0;
      if (abort_cols > 0 && r == rows - 1) begin
        repeat (8) @(negedge clk);
        return;
      end
      hr = 1'b0;
      repeat (3) @(negedge clk);
    end
    vs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 8'(r * 16 + c + 1);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hand_tab[0] = 8'd5; hand_tab[1] = 8'd1; hand_tab[2] = 8'd9; hand_tab[3] = 8'd7;
    rst_n = 1'b0; mode = 2'd0; vs = 1'b0; hr = 1'b0; ck = 1'b0; yin = 8'h00;
    #1;
    chk8("rst_vsync", {7'd0, post_frame_vsync}, 8'h00);
    chk8("rst_href",  {7'd0, post_frame_href},  8'h00);
    chk8("rst_clken", {7'd0, post_frame_clken}, 8'h00);
    chk8("rst_Y",     post_img_Y,               8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Flat frame, median.
    fill_const(8'h55);
    send_frame(4, 2'd0, 2'd0, -1, 1'b0, 1'b0, 0, 1'b0);

    // Impulse at (2,3): median, max, min.
    fill_const(8'h00);
    img[2][3] = 8'hFF;
    send_frame(6, 2'd0, 2'd0, -1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(6, 2'd2, 2'd2, -1, 1'b0, 1'b0, 0, 1'b0);
    send_frame(6, 2'd1, 2'd1, -1, 1'b0, 1'b0, 0, 1'b0);

    // Hand-computed window at newest (2,2) in all four modes.
    fill_ramp();
    img[0][0] = 8'd9; img[0][1] = 8'd1; img[0][2] = 8'd5;
    img[1][0] = 8'd3; img[1][1] = 8'd7; img[1][2] = 8'd2;
    img[2][0] = 8'd8; img[2][1] = 8'd4; img[2][2] = 8'd6;
    for (int m = 0; m < 4; m++) begin
      send_frame(3, 2'(m), 2'(m), -1, 1'b0, 1'b0, 0, 1'b1);
    end

    // Ramp frame: border handling.
    fill_ramp();
    send_frame(5, 2'd0, 2'd0, -1, 1'b0, 1'b0, 0, 1'b0);

    // Mode 0->2 mid-frame, then max frames with and without clken gaps.
    send_frame(5, 2'd0, 2'd2, 2, 1'b0, 1'b0, 0, 1'b0);
    send_frame(5, 2'd2, 2'd2, -1, 1'b1, 1'b0, 0, 1'b0);
    send_frame(5, 2'd2, 2'd2, -1, 1'b0, 1'b0, 0, 1'b0);

    // Reset mid-line with href high.
    send_frame(4, 2'd0, 2'd0, -1, 1'b0, 1'b0, 5, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk8("midrst_vsync", {7'd0, post_frame_vsync}, 8'h00);
    chk8("midrst_href",  {7'd0, post_frame_href},  8'h00);
    chk8("midrst_clken", {7'd0, post_frame_clken}, 8'h00);
    chk8("midrst_Y",     post_img_Y,               8'h00);
    chk8("midrst_pending", 8'(sb_q.size()), 8'h00);
    sb_q.delete();
    hr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(4, 2'd2, 2'd2, -1, 1'b0, 1'b1, 0, 1'b0);

    repeat (20) @(negedge clk);
    chk8("leftover", 8'(sb_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
